// File: rtl/adder_32bit_pkg.sv
// Shared sizing for the registered 32-bit carry-lookahead adder.
package adder_32bit_pkg;
  localparam int ADDER_WIDTH = 32;
  localparam int SLICE_W     = 4;
  localparam int NUM_SLICES  = ADDER_WIDTH / SLICE_W;
endpackage

// File: rtl/adder_32bit_cla_4b.sv
// 4-bit lookahead slice: purely combinational bit sums plus group generate/propagate.
// No state and no flow control; carries inside the slice are fully flattened.
module cla_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       G,
  output logic       P
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;
endmodule

// File: rtl/adder_32bit.sv
// Registered 32-bit two-level CLA adder with carry and signed-overflow flags; latency 1 cycle.
// Accepts new operands every clk edge, no handshake or stall.
module adder_32bit
  import adder_32bit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDER_WIDTH-1:0] op1,
  input  logic [ADDER_WIDTH-1:0] op2,
  output logic [ADDER_WIDTH-1:0] result,
  output logic                   carry_out,
  output logic                   overflow
);
  logic [NUM_SLICES-1:0]  grp_g;
  logic [NUM_SLICES-1:0]  grp_p;
  logic [NUM_SLICES:0]    carry;
  logic [ADDER_WIDTH-1:0] sum;
  logic                   ovf;

  for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
    cla_4b u_cla (
      .a   (op1[SLICE_W*i +: SLICE_W]),
      .b   (op2[SLICE_W*i +: SLICE_W]),
      .cin (carry[i]),
      .s   (sum[SLICE_W*i +: SLICE_W]),
      .G   (grp_g[i]),
      .P   (grp_p[i])
    );
  end

  // Each slice carry is a flat sum of products over the lower slices' (G, P), with c0 = 0.
  always_comb begin
    logic term;
    term  = 1'b0;
    carry = '0;
    for (int j = 1; j <= NUM_SLICES; j++) begin
      for (int k = 0; k < j; k++) begin
        term = grp_g[k];
        for (int m = k + 1; m < j; m++) begin
          term = term & grp_p[m];
        end
        carry[j] = carry[j] | term;
      end
    end
  end

  assign ovf = (op1[ADDER_WIDTH-1] == op2[ADDER_WIDTH-1]) &&
               (sum[ADDER_WIDTH-1] != op1[ADDER_WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      result    <= sum;
      carry_out <= carry[NUM_SLICES];
      overflow  <= ovf;
    end
  end
endmodule

// File: tb/tb_adder_32bit.sv
// Bench for adder_32bit: directed vector table, hand-written reset sequences, random vs. arithmetic model.
module tb_adder_32bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_c;
    logic        exp_v;
  } vec_t;

  vec_t vecs[$];

  adder_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op1       (op1),
    .op2       (op2),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [31:0] r, input logic c, input logic v);
    chk({name, ".result"}, result, r);
    chk({name, ".carry"}, {31'b0, carry_out}, {31'b0, c});
    chk({name, ".ovf"}, {31'b0, overflow}, {31'b0, v});
  endtask

  // Drive operands mid-cycle, then sample just after the capturing edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op1 = a;
    op2 = b;
    @(posedge clk);
    #1;
  endtask

  // Reference from plain arithmetic: unsigned 33-bit sum and signed range test.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic v);
    longint unsigned us;
    longint          ss;
    us = longint'(a) + longint'(b);
    ss = longint'($signed(a)) + longint'($signed(b));
    r  = us[31:0];
    c  = us >= 64'h1_0000_0000;
    v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mr;
    logic        mc;
    logic        mv;

    vecs.push_back('{32'd5,         32'd4,         32'd9,         1'b0, 1'b0});
    vecs.push_back('{32'd11,        32'd8,         32'd19,        1'b0, 1'b0});
    vecs.push_back('{32'd65,        32'd100,       32'd165,       1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF,  32'd1,         32'h00000000,  1'b1, 1'b0});
    vecs.push_back('{32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0, 1'b1});
    vecs.push_back('{32'h80000000,  32'h80000000,  32'h00000000,  1'b1, 1'b1});
    vecs.push_back('{32'h0000FFFF,  32'd1,         32'h00010000,  1'b0, 1'b0});
    vecs.push_back('{32'h0FFFFFFF,  32'd1,         32'h10000000,  1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b1, 1'b0});
    vecs.push_back('{32'h80000000,  32'hFFFFFFFF,  32'h7FFFFFFF,  1'b1, 1'b1});

    // Asynchronous reset clears outputs before any clock edge.
    op1 = 32'd5;
    op2 = 32'd4;
    #1 rst_n = 1'b0;
    #1;
    chk_all("reset_async", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reset_held_edge", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_c, vecs[i].exp_v);
    end

    // Operand change between edges must not disturb the registered outputs.
    step(32'd1000, 32'd234);
    @(negedge clk);
    op1 = 32'hFFFFFFFF;
    op2 = 32'hFFFFFFFF;
    #1;
    chk_all("hold_between_edges", 32'd1234, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("after_hold_edge", 32'hFFFFFFFE, 1'b1, 1'b0);

    // Mid-stream reset discards the in-flight sum.
    step(32'd65, 32'd100);
    chk_all("pre_midreset", 32'd165, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("midreset_async", 32'h0, 1'b0, 1'b0);
    op1 = 32'd3;
    op2 = 32'd4;
    @(posedge clk);
    #1;
    chk_all("midreset_held", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("after_midreset", 32'd7, 1'b0, 1'b0);

    // Random operands, biased sometimes toward sign-boundary values.
    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra[30:0] = {31{ra[0]}};
      if ($urandom_range(0, 3) == 0) rb = ~ra + {31'b0, rb[0]};
      model(ra, rb, mr, mc, mv);
      step(ra, rb);
      chk_all($sformatf("rand%0d", n), mr, mc, mv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
